move_scheduler: RTL

- Sequences the player position datapath: converts held direction buttons into rate-limited single-pixel step commands over a valid/ready handshake.
- Checks the datapath's collision result after each step and issues a corrective undo step when the move was blocked.
- Sits between the debounced button inputs and the player position register block.
- Owns the game-over (DEAD) lockout for movement.

---
 rtl/move_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/move_scheduler.sv
// Player step sequencer: held buttons -> rate-limited step commands, undo on collision.
// Optional MOVE_SCHED_ACCEL_EN halves the step period after a run of 8 unblocked steps.
module move_scheduler #(
  parameter int STEP_TICKS = 150000,
  parameter int TIMER_W    = 19
) (
  input  logic       CLOCK_25,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       step_ready,
  input  logic       collision,
  output logic       step_valid,
  output logic [1:0] step_dir,
  output logic       step_undo,
  output logic       dead,
  output logic [7:0] blocked_cnt,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_UNDO  = 3'd4;
  localparam logic [2:0] S_DEAD  = 3'd5;

  localparam logic [TIMER_W-1:0] TERM_FULL =
    TIMER_W'(STEP_TICKS - 1);

  logic [2:0]         state, state_nx;
  logic [TIMER_W-1:0] timer, timer_nx;
  logic [1:0]         dir, dir_nx;
  logic [7:0]         blk_nx;
  logic [3:0]         pressed;
  logic [1:0]         pick;
  logic               held;
  logic [TIMER_W-1:0] term;

  // Indexed by direction code so the latched dir selects its own button
  assign pressed = {~btn_right, ~btn_left, ~btn_down, ~btn_up};
  assign held    = pressed[dir];

`ifdef MOVE_SCHED_ACCEL_EN
  localparam logic [TIMER_W-1:0] TERM_HALF =
    TIMER_W'((STEP_TICKS >> 1) - 1);

  logic [3:0] run, run_nx;

  assign term = (run >= 4'd8) ? TERM_HALF : TERM_FULL;

  always_comb begin
    run_nx = run;
    if (state == S_CHECK) begin
      if (collision)
        run_nx = 4'd0;
      else if (held && run != 4'hF)
        run_nx = run + 4'd1;
    end
    if (state_nx == S_IDLE)
      run_nx = 4'd0;
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) run <= 4'd0;
    else          run <= run_nx;
  end
`else
  assign term = TERM_FULL;
`endif

  // Fixed priority: left > down > up > right
  always_comb begin
    if (pressed[2])      pick = 2'd2;
    else if (pressed[1]) pick = 2'd1;
    else if (pressed[0]) pick = 2'd0;
    else                 pick = 2'd3;
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    dir_nx   = dir;
    blk_nx   = blocked_cnt;
    unique case (state)
      S_IDLE: begin
        if (!enable) begin
          state_nx = S_DEAD;
        end else if (|pressed) begin
          dir_nx   = pick;
          timer_nx = '0;
          state_nx = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!enable) begin
          state_nx = S_DEAD;
          timer_nx = '0;
        end else if (!held) begin
          state_nx = S_IDLE;
          timer_nx = '0;
        end else if (timer == term) begin
          state_nx = S_ISSUE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_ISSUE: begin
        if (step_ready)
          state_nx = enable ? S_CHECK : S_DEAD;
      end
      S_CHECK: begin
        if (collision && blocked_cnt != 8'hFF)
          blk_nx = blocked_cnt + 8'd1;
        if (!enable) begin
          state_nx = S_DEAD;
        end else if (collision) begin
          state_nx = S_UNDO;
        end else if (held) begin
          state_nx = S_COUNT;
          timer_nx = '0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_UNDO: begin
        if (step_ready)
          state_nx = enable ? S_IDLE : S_DEAD;
      end
      S_DEAD: state_nx = S_DEAD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      dir         <= 2'd0;
      blocked_cnt <= 8'd0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      dir         <= dir_nx;
      blocked_cnt <= blk_nx;
    end
  end

  // Undo flips within each axis: up<->down, left<->right
  always_comb begin
    step_valid = 1'b0;
    step_undo  = 1'b0;
    step_dir   = 2'd0;
    unique case (1'b1)
      (state == S_ISSUE): begin
        step_valid = 1'b1;
        step_dir   = dir;
      end
      (state == S_UNDO): begin
        step_valid = 1'b1;
        step_undo  = 1'b1;
        step_dir   = dir ^ 2'b01;
      end
      default: ;
    endcase
  end

  assign dead      = (state == S_DEAD);
  assign state_dbg = state;

endmodule
